// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-PC sequencer: FSM states, redirect-source codes, bundle stride.
package fetch_ctrl_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REFILL = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_ID     = 2'd1,
        SRC_EX     = 2'd2,
        SRC_COMMIT = 2'd3
    } redirect_src_e;

    localparam int unsigned FETCH_BANDWIDTH_DEF = 4;
    localparam int unsigned INST_BYTES_DEF      = 8;

    function automatic int unsigned bundle_stride(input int unsigned bw, input int unsigned ib);
        return bw * ib;
    endfunction

    localparam int unsigned STRIDE_DEF = bundle_stride(FETCH_BANDWIDTH_DEF, INST_BYTES_DEF);

endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Increment-and-saturate event counter; sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-PC sequencer: owns the fetch PC, arbitrates redirects, squashes FS1/FS2 and
// inserts refill bubbles after every applied redirect.
//
// state     | meaning
// ST_RUN    | fetching, pc_o is live
// ST_REFILL | bubble countdown after a redirect, no fetch issued
module fetch_redirect_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned         SIZE_PC         = 32,
    parameter int unsigned         FETCH_BANDWIDTH = FETCH_BANDWIDTH_DEF,
    parameter int unsigned         INST_BYTES      = INST_BYTES_DEF,
    parameter logic [SIZE_PC-1:0]  RESET_PC        = '0,
    parameter int unsigned         REFILL_BUBBLES  = 1,
    parameter int unsigned         CNT_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               ctiQueueFull_i,
    input  logic               recoverFlag_i,
    input  logic [SIZE_PC-1:0] recoverPC_i,
    input  logic               flagRecoverEX_i,
    input  logic [SIZE_PC-1:0] targetAddrEX_i,
    input  logic               flagRecoverID_i,
    input  logic [SIZE_PC-1:0] targetAddrID_i,
    input  logic               btbTaken_i,
    input  logic [SIZE_PC-1:0] btbTarget_i,
    output logic [SIZE_PC-1:0] pc_o,
    output logic               fetchValid_o,
    output logic               flushFS1_o,
    output logic               flushFS2_o,
    output logic [1:0]         redirectSrc_o,
    output logic [CNT_W-1:0]   cntCommit_o,
    output logic [CNT_W-1:0]   cntEX_o,
    output logic [CNT_W-1:0]   cntID_o
);

    localparam logic [SIZE_PC-1:0] STRIDE  = SIZE_PC'(bundle_stride(FETCH_BANDWIDTH, INST_BYTES));
    localparam logic [2:0]         BUBBLES = 3'(REFILL_BUBBLES);

    fetch_state_e        state_q, state_d;
    logic [2:0]          bubble_q, bubble_d;
    logic [SIZE_PC-1:0]  pc_q, pc_d;
    redirect_src_e       src_q, src_d;
    logic                fetch_valid_q;
    logic                flush1_q, flush2_q;
    logic                prev_hard_q;

    logic hard_redirect, id_accept, any_redirect, advance, ex_apply;

    always_comb begin
        hard_redirect = recoverFlag_i | flagRecoverEX_i;
        // FS2 holds wrong-path contents right after a commit/EX redirect
        id_accept     = flagRecoverID_i & ~hard_redirect & ~prev_hard_q;
        any_redirect  = hard_redirect | id_accept;
        ex_apply      = flagRecoverEX_i & ~recoverFlag_i;
        advance       = fetch_valid_q & ~stall_i & ~ctiQueueFull_i;

        pc_d  = pc_q;
        src_d = src_q;
        if (recoverFlag_i) begin
            pc_d  = recoverPC_i;
            src_d = SRC_COMMIT;
        end else if (flagRecoverEX_i) begin
            pc_d  = targetAddrEX_i;
            src_d = SRC_EX;
        end else if (id_accept) begin
            pc_d  = targetAddrID_i;
            src_d = SRC_ID;
        end else if (advance && btbTaken_i) begin
            pc_d = btbTarget_i;
        end else if (advance) begin
            pc_d = pc_q + STRIDE;
        end

        state_d  = state_q;
        bubble_d = bubble_q;
        if (any_redirect) begin
            if (BUBBLES == 3'd0) begin
                state_d  = ST_RUN;
                bubble_d = 3'd0;
            end else begin
                state_d  = ST_REFILL;
                bubble_d = BUBBLES;
            end
        end else if (state_q == ST_REFILL) begin
            if (bubble_q <= 3'd1) begin
                state_d  = ST_RUN;
                bubble_d = 3'd0;
            end else begin
                bubble_d = bubble_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            bubble_q      <= 3'd0;
            pc_q          <= RESET_PC;
            src_q         <= SRC_NONE;
            fetch_valid_q <= 1'b0;
            flush1_q      <= 1'b0;
            flush2_q      <= 1'b0;
            prev_hard_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bubble_q      <= bubble_d;
            pc_q          <= pc_d;
            src_q         <= src_d;
            fetch_valid_q <= (state_d == ST_RUN);
            flush1_q      <= any_redirect;
            flush2_q      <= hard_redirect;
            prev_hard_q   <= hard_redirect;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_commit (
        .clk   (clk),
        .reset (reset),
        .inc_i (recoverFlag_i),
        .cnt_o (cntCommit_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_ex (
        .clk   (clk),
        .reset (reset),
        .inc_i (ex_apply),
        .cnt_o (cntEX_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_id (
        .clk   (clk),
        .reset (reset),
        .inc_i (id_accept),
        .cnt_o (cntID_o)
    );

    assign pc_o          = pc_q;
    assign fetchValid_o  = fetch_valid_q;
    assign flushFS1_o    = flush1_q;
    assign flushFS2_o    = flush2_q;
    assign redirectSrc_o = src_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: vector table plus hand sequences for saturation and reset.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, ctiQueueFull_i;
    logic        recoverFlag_i, flagRecoverEX_i, flagRecoverID_i, btbTaken_i;
    logic [31:0] recoverPC_i, targetAddrEX_i, targetAddrID_i, btbTarget_i;

    logic [31:0] pc_o, pc2_o;
    logic        fetchValid_o, flushFS1_o, flushFS2_o;
    logic        fv2_o, f1_2_o, f2_2_o;
    logic [1:0]  redirectSrc_o, src2_o;
    logic [15:0] cntCommit_o, cntEX_o, cntID_o;
    logic [1:0]  cc2_o, ce2_o, ci2_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .ctiQueueFull_i(ctiQueueFull_i),
        .recoverFlag_i(recoverFlag_i), .recoverPC_i(recoverPC_i),
        .flagRecoverEX_i(flagRecoverEX_i), .targetAddrEX_i(targetAddrEX_i),
        .flagRecoverID_i(flagRecoverID_i), .targetAddrID_i(targetAddrID_i),
        .btbTaken_i(btbTaken_i), .btbTarget_i(btbTarget_i),
        .pc_o(pc_o), .fetchValid_o(fetchValid_o), .flushFS1_o(flushFS1_o),
        .flushFS2_o(flushFS2_o), .redirectSrc_o(redirectSrc_o),
        .cntCommit_o(cntCommit_o), .cntEX_o(cntEX_o), .cntID_o(cntID_o)
    );

    fetch_redirect_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall_i(stall_i), .ctiQueueFull_i(ctiQueueFull_i),
        .recoverFlag_i(recoverFlag_i), .recoverPC_i(recoverPC_i),
        .flagRecoverEX_i(flagRecoverEX_i), .targetAddrEX_i(targetAddrEX_i),
        .flagRecoverID_i(flagRecoverID_i), .targetAddrID_i(targetAddrID_i),
        .btbTaken_i(btbTaken_i), .btbTarget_i(btbTarget_i),
        .pc_o(pc2_o), .fetchValid_o(fv2_o), .flushFS1_o(f1_2_o),
        .flushFS2_o(f2_2_o), .redirectSrc_o(src2_o),
        .cntCommit_o(cc2_o), .cntEX_o(ce2_o), .cntID_o(ci2_o)
    );

    typedef struct {
        bit          stall, cti, rec;
        logic [31:0] rec_pc;
        bit          ex;
        logic [31:0] ex_pc;
        bit          id;
        logic [31:0] id_pc;
        bit          btb;
        logic [31:0] btb_pc;
        logic [31:0] e_pc;
        bit          e_valid, e_f1, e_f2;
        logic [1:0]  e_src;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall_i = 0; ctiQueueFull_i = 0;
        recoverFlag_i = 0; recoverPC_i = '0;
        flagRecoverEX_i = 0; targetAddrEX_i = '0;
        flagRecoverID_i = 0; targetAddrID_i = '0;
        btbTaken_i = 0; btbTarget_i = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //               stall cti rec rec_pc        ex ex_pc         id id_pc         btb btb_pc        e_pc          v  f1 f2 src
        vecs[0]  = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0000_0000, 1, 0, 0, 2'd0};
        vecs[1]  = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0000_0020, 1, 0, 0, 2'd0};
        vecs[2]  = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0000_0040, 1, 0, 0, 2'd0};
        vecs[3]  = '{1, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    1, 32'h1000, 32'h0000_0040, 1, 0, 0, 2'd0};
        vecs[4]  = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    1, 32'h1000, 32'h0000_1000, 1, 0, 0, 2'd0};
        vecs[5]  = '{0, 1, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0000_1000, 1, 0, 0, 2'd0};
        vecs[6]  = '{1, 0, 0, 32'h0,   1, 32'h2000,      0, 32'h0,    0, 32'h0,    32'h0000_2000, 0, 1, 1, 2'd2};
        vecs[7]  = '{1, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0000_2000, 1, 0, 0, 2'd2};
        vecs[8]  = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0000_2020, 1, 0, 0, 2'd2};
        vecs[9]  = '{0, 0, 1, 32'h500, 1, 32'h600,       1, 32'h700,  1, 32'h900,  32'h0000_0500, 0, 1, 1, 2'd3};
        vecs[10] = '{0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h700,  0, 32'h0,    32'h0000_0500, 1, 0, 0, 2'd3};
        vecs[11] = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0000_0520, 1, 0, 0, 2'd3};
        vecs[12] = '{0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h3000, 0, 32'h0,    32'h0000_3000, 0, 1, 0, 2'd1};
        vecs[13] = '{0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h3100, 0, 32'h0,    32'h0000_3100, 0, 1, 0, 2'd1};
        vecs[14] = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    1, 32'h4000, 32'h0000_3100, 1, 0, 0, 2'd1};
        vecs[15] = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0000_3120, 1, 0, 0, 2'd1};
        vecs[16] = '{0, 0, 0, 32'h0,   1, 32'hFFFF_FFE0, 0, 32'h0,    0, 32'h0,    32'hFFFF_FFE0, 0, 1, 1, 2'd2};
        vecs[17] = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'hFFFF_FFE0, 1, 0, 0, 2'd2};
        vecs[18] = '{0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0000_0000, 1, 0, 0, 2'd2};

        idle_inputs();
        reset = 1;
        step();
        step();
        check("reset_pc",    pc_o, 32'h0);
        check("reset_valid", 32'(fetchValid_o), 32'h0);
        check("reset_flush", {30'h0, flushFS1_o, flushFS2_o}, 32'h0);
        check("reset_src",   32'(redirectSrc_o), 32'h0);
        check("reset_cnt",   {cntCommit_o, cntEX_o | cntID_o}, 32'h0);
        reset = 0;

        for (int i = 0; i < NV; i++) begin
            stall_i = vecs[i].stall;   ctiQueueFull_i = vecs[i].cti;
            recoverFlag_i = vecs[i].rec;   recoverPC_i = vecs[i].rec_pc;
            flagRecoverEX_i = vecs[i].ex;  targetAddrEX_i = vecs[i].ex_pc;
            flagRecoverID_i = vecs[i].id;  targetAddrID_i = vecs[i].id_pc;
            btbTaken_i = vecs[i].btb;      btbTarget_i = vecs[i].btb_pc;
            step();
            check($sformatf("v%0d_pc", i),    pc_o, vecs[i].e_pc);
            check($sformatf("v%0d_valid", i), 32'(fetchValid_o), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_fs1", i),   32'(flushFS1_o), 32'(vecs[i].e_f1));
            check($sformatf("v%0d_fs2", i),   32'(flushFS2_o), 32'(vecs[i].e_f2));
            check($sformatf("v%0d_src", i),   32'(redirectSrc_o), 32'(vecs[i].e_src));
        end
        idle_inputs();

        check("cnt_commit", 32'(cntCommit_o), 32'd1);
        check("cnt_ex",     32'(cntEX_o), 32'd2);
        check("cnt_id",     32'(cntID_o), 32'd2);
        check("cnt2_ex",    32'(ce2_o), 32'd2);

        // five back-to-back EX redirects: wide counter counts all, 2-bit counter sticks at 3
        for (int k = 0; k < 5; k++) begin
            flagRecoverEX_i = 1; targetAddrEX_i = 32'h100 + 32'(k);
            step();
        end
        idle_inputs();
        check("sat_ex_wide", 32'(cntEX_o), 32'd7);
        check("sat_ex_2bit", 32'(ce2_o), 32'd3);
        check("sat_commit_2bit", 32'(cc2_o), 32'd1);
        check("sat_pc", pc_o, 32'h104);

        // reset while stalled in REFILL
        stall_i = 1;
        flagRecoverEX_i = 1; targetAddrEX_i = 32'h7000;
        step();
        flagRecoverEX_i = 0;
        check("pre_rst_valid", 32'(fetchValid_o), 32'h0);
        reset = 1;
        step();
        check("mid_rst_pc",    pc_o, 32'h0);
        check("mid_rst_valid", 32'(fetchValid_o), 32'h0);
        check("mid_rst_flush", {30'h0, flushFS1_o, flushFS2_o}, 32'h0);
        check("mid_rst_src",   32'(redirectSrc_o), 32'h0);
        check("mid_rst_cnt",   {cntCommit_o, cntEX_o}, 32'h0);
        reset = 0;
        stall_i = 0;
        step();
        check("post_rst_pc",    pc_o, 32'h0);
        check("post_rst_valid", 32'(fetchValid_o), 32'h1);
        step();
        check("post_rst_adv",   pc_o, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Fetch-PC sequencer for the two-stage front end. It owns the fetch PC register and picks the next fetch address each cycle. Candidates are commit recovery, execute mispredict, FetchStage2 pre-decode redirect, FetchStage1 BTB prediction, and the sequential bundle address. It also generates the FS1/FS2 squash strobes, inserts refill bubbles after redirects and keeps per-source redirect counters.

## Interface
- SIZE_PC, 32: PC width.
- FETCH_BANDWIDTH, 4: instructions per bundle.
- INST_BYTES, 8: bytes per instruction; bundle stride = FETCH_BANDWIDTH*INST_BYTES.
- RESET_PC, 32'h0000_0000: PC loaded by reset.
- REFILL_BUBBLES, 1: idle cycles after any redirect (0..7).
- CNT_W, 16: redirect-counter width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall_i  in  1  back-pressure from decode; PC holds.
- ctiQueueFull_i  in  1  CTI queue full; PC holds.
- recoverFlag_i  in  1  commit-level recovery request.
- recoverPC_i  in  SIZE_PC  commit recovery target.
- flagRecoverEX_i  in  1  execute branch mispredict.
- targetAddrEX_i  in  SIZE_PC  execute redirect target.
- flagRecoverID_i  in  1  FetchStage2 pre-decode redirect.
- targetAddrID_i  in  SIZE_PC  FetchStage2 redirect target.
- btbTaken_i  in  1  FS1 BTB hit with taken prediction for the current bundle.
- btbTarget_i  in  SIZE_PC  predicted target.
- pc_o  out  SIZE_PC  current fetch PC to FS1/I-cache.
- fetchValid_o  out  1  pc_o is a live fetch this cycle.
- flushFS1_o  out  1  squash FS1 pipeline register.
- flushFS2_o  out  1  squash FS2 pipeline register.
- redirectSrc_o  out  2  source of the last applied redirect: 0 none, 1 ID, 2 EX, 3 commit.
- cntCommit_o, cntEX_o, cntID_o  out  CNT_W each  saturating redirect counters.

## Operation
- advance = fetchValid_o & ~stall_i & ~ctiQueueFull_i.
- Next-PC priority, evaluated every cycle:
  1. recoverFlag_i
  2. flagRecoverEX_i
  3. accepted flagRecoverID_i
  4. btbTaken_i, only if advance
  5. pc_o + stride, only if advance
  6. hold
- Redirects from sources 1-3 apply regardless of stall_i or ctiQueueFull_i.
- Commit or EX redirect: pulse flushFS1_o and flushFS2_o for one cycle.
- ID redirect: pulse flushFS1_o only.
- ID acceptance:
  - flagRecoverID_i is dropped if commit or EX recovery is asserted in the same cycle.
  - It is also dropped in the cycle immediately after a commit or EX redirect, because FS2 then holds wrong-path contents.
  - A dropped ID redirect does not count.
- FSM states:
  - RUN: fetching.
  - REFILL: bubble countdown.
- Transitions:
  - Any applied redirect goes to REFILL with bubble counter = REFILL_BUBBLES. If REFILL_BUBBLES = 0, it stays in RUN.
  - REFILL decrements the counter each cycle and returns to RUN when the counter reaches 1.
  - A new redirect during REFILL reloads the counter.
  - stall_i does not freeze the countdown.
- fetchValid_o = (state==RUN). A BTB prediction with fetchValid_o low is ignored.
- PC arithmetic is modulo 2^SIZE_PC: 0xFFFF_FFE0 + 32 = 0x0000_0000, with no error flag.
- Counters increment by one per applied redirect of their source and saturate at all-ones.

## Timing
- All outputs are registered.
- Redirect inputs sampled at edge N appear on pc_o and the flush strobes after edge N; the flush strobes are high during cycle N+1.
- With REFILL_BUBBLES = B, fetchValid_o is low for B cycles after the redirect PC appears, then high.
- Reset values: pc_o = RESET_PC, fetchValid_o = 0, flush strobes = 0, redirectSrc_o = 0, counters = 0, state = RUN.
- The first fetch after reset: fetchValid_o = 1 in the first cycle after reset is sampled low.
- Reset asserted mid-REFILL or mid-stall overrides everything within one edge.

## Structure
- Shared package fetch_ctrl_pkg holds:
  - the state encoding (RUN, REFILL);
  - the redirect-source codes;
  - the stride constant.
- One sub-module, sat_counter (CNT_W-wide increment-saturate), is instantiated three times.
- Everything else stays in fetch_redirect_ctrl.

## Test plan
- **Reset, then free run:** reset 2 cycles, no stimulus → pc_o 0x0, 0x20, 0x40 on consecutive cycles, fetchValid_o = 1.
- **BTB taken at PC 0x40, target 0x1000:** next pc_o = 0x1000 with no bubble and no flush. Repeat with stall_i high → pc_o holds 0x40.
- **EX mispredict, target 0x2000, while stall_i high:** next cycle pc_o = 0x2000, flushFS1_o = flushFS2_o = 1, redirectSrc_o = 2, fetchValid_o = 0 for 1 cycle, cntEX_o = 1.
- **Commit recovery to 0x500 and EX/ID redirects in the same cycle:** pc_o = 0x500, redirectSrc_o = 3. An ID redirect asserted on the following cycle is ignored and cntID_o stays 0.
- **ID redirect to 0x3000 alone:** pc_o = 0x3000, only flushFS1_o pulses. A second ID redirect during REFILL reloads the bubble.
- **Wrap and saturation:** pc_o at 0xFFFF_FFE0 advancing → 0x0. With CNT_W forced to 2, 5 EX redirects → cntEX_o = 3.
